cpu_mem_arbiter: RTL and testbench

- Shares one unified single-port memory between two requesters: the IF stage (instruction fetch) and the MEM stage (data load/store).
- Sits between the pipeline stages and the memory model clocked on clk_i.
- Allows one outstanding transaction at a time. Data requests win by default, and a starvation guard guarantees fetch progress.
- Routes each response back to the requester that issued it.

---
 rtl/cpu_mem_arbiter_pkg.sv | 14 +
 rtl/cpu_mem_arbiter_if.sv | 52 +++++
 rtl/cpu_mem_arbiter_pick.sv | 38 +++
 rtl/cpu_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory arbiter.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundles the fetch, data and memory buses seen by the arbiter.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic                dm_req_i;
  logic                dm_we_i;
  logic [DATA_W/8-1:0] dm_be_i;
  logic [ADDR_W-1:0]   dm_addr_i;
  logic [DATA_W-1:0]   dm_wdata_i;
  logic                dm_gnt_o;
  logic                dm_rvalid_o;
  logic [DATA_W-1:0]   dm_rdata_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [DATA_W-1:0]   mem_rdata_i;

  logic busy_o;
  logic err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output busy_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  busy_o, err_o
  );
endinterface

// File: rtl/cpu_mem_arbiter_pick.sv
// Priority decision (data first) with a starvation counter that forces a fetch win.
module mem_arb_pick
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   if_req_i,
  input  logic   dm_req_i,
  input  logic   arb_en_i,
  output owner_t winner_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       starved;

  assign starved = (cnt_q == 4'(STARVE_LIMIT));

  always_comb begin
    winner_o = OWN_IF;
    if (dm_req_i && !(if_req_i && starved)) winner_o = OWN_DM;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (arb_en_i) begin
      if (if_req_i && winner_o == OWN_DM) cnt_d = starved ? cnt_q : cnt_q + 4'd1;
      else                                cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 4'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares a single-port memory between fetch and data ports, one transaction in flight.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk_i,
  input logic rst_ni,
  cpu_mem_arbiter_if.slave bus
);

  localparam int BE_W = be_width(DATA_W);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic   req_any, arb_en;
  owner_t winner;
  logic   if_gnt, dm_gnt, if_rvalid, dm_rvalid, err;

  assign req_any = bus.if_req_i | bus.dm_req_i;
  assign arb_en  = (state_q == IDLE) && req_any;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .if_req_i (bus.if_req_i),
    .dm_req_i (bus.dm_req_i),
    .arb_en_i (arb_en),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: if (req_any) begin
        state_d = REQ;
        owner_d = winner;
        if (winner == OWN_DM) begin
          mem_we_d    = bus.dm_we_i;
          mem_be_d    = bus.dm_be_i;
          mem_addr_d  = bus.dm_addr_i;
          mem_wdata_d = bus.dm_wdata_i;
        end else begin
          // fetches are always full-word reads; no byte lanes or write data
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = bus.if_addr_i;
          mem_wdata_d = '0;
        end
      end
      REQ:     if (bus.mem_gnt_i)    state_d = RSP;
      RSP:     if (bus.mem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_en) begin
          if_gnt = (winner == OWN_IF);
          dm_gnt = (winner == OWN_DM);
        end
        err = bus.mem_rvalid_i;
      end
      REQ: err = bus.mem_rvalid_i;
      RSP: if (bus.mem_rvalid_i) begin
        if_rvalid = (owner_q == OWN_IF);
        dm_rvalid = (owner_q == OWN_DM);
      end
      default: err = 1'b0;
    endcase
    // keep handshake pulses quiet while reset is held, even with requests pending
    if (!rst_ni) begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      err    = 1'b0;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.dm_gnt_o    = dm_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.dm_rvalid_o = dm_rvalid;
  assign bus.if_rdata_o  = bus.mem_rdata_i;
  assign bus.dm_rdata_o  = bus.mem_rdata_i;
  assign bus.mem_req_o   = (state_q == REQ);
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.err_o       = err;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: inputs driven on negedge, outputs sampled 1ns later.
module tb_cpu_mem_arbiter;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_be_i = '0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_single_fetch();
    do_reset();
    @(negedge clk_i); bus.if_req_i = 1; bus.if_addr_i = 32'h10; #1;
    n_chk++; if (bus.if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt got %b want 1", bus.if_gnt_o); end
    n_chk++; if (bus.dm_gnt_o !== 1'b0) begin n_fail++; $display("FAIL fetch_no_dm_gnt got %b want 0", bus.dm_gnt_o); end
    @(negedge clk_i); bus.if_req_i = 0; bus.mem_gnt_i = 1; #1;
    n_chk++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 6'b1_0_0000) begin n_fail++; $display("FAIL fetch_mem_ctl got %b want 100000", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}); end
    n_chk++; if (bus.mem_addr_o !== 32'h10) begin n_fail++; $display("FAIL fetch_mem_addr got %h want 00000010", bus.mem_addr_o); end
    @(negedge clk_i); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h00500093; #1;
    n_chk++; if (bus.if_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid got %b want 1", bus.if_rvalid_o); end
    n_chk++; if (bus.if_rdata_o !== 32'h00500093) begin n_fail++; $display("FAIL fetch_rdata got %h want 00500093", bus.if_rdata_o); end
    n_chk++; if (bus.dm_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fetch_dm_rvalid got %b want 0", bus.dm_rvalid_o); end
    n_chk++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL fetch_rsp_req got %b want 0", bus.mem_req_o); end
    @(negedge clk_i); bus.mem_rvalid_i = 0; #1;
    n_chk++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL fetch_idle_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_both_requests();
    do_reset();
    @(negedge clk_i);
    bus.if_req_i = 1; bus.if_addr_i = 32'h20;
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h40; bus.dm_wdata_i = 32'hDEADBEEF; #1;
    n_chk++; if ({bus.dm_gnt_o, bus.if_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL both_first_gnt dm/if got %b want 10", {bus.dm_gnt_o, bus.if_gnt_o}); end
    @(negedge clk_i); bus.dm_req_i = 0; bus.mem_gnt_i = 1; #1;
    n_chk++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 6'b1_1_1111) begin n_fail++; $display("FAIL both_store_ctl got %b want 111111", {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}); end
    n_chk++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== {32'h40, 32'hDEADBEEF}) begin n_fail++; $display("FAIL both_store_bus got %h/%h want 00000040/deadbeef", bus.mem_addr_o, bus.mem_wdata_o); end
    n_chk++; if (bus.if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL both_if_wait got %b want 0", bus.if_gnt_o); end
    @(negedge clk_i); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; #1;
    n_chk++; if ({bus.dm_rvalid_o, bus.if_rvalid_o} !== 2'b10) begin n_fail++; $display("FAIL both_store_ack dm/if got %b want 10", {bus.dm_rvalid_o, bus.if_rvalid_o}); end
    @(negedge clk_i); bus.mem_rvalid_i = 0; #1;
    n_chk++; if ({bus.dm_gnt_o, bus.if_gnt_o} !== 2'b01) begin n_fail++; $display("FAIL both_second_gnt dm/if got %b want 01", {bus.dm_gnt_o, bus.if_gnt_o}); end
    @(negedge clk_i); bus.if_req_i = 0; bus.mem_gnt_i = 1; #1;
    n_chk++; if ({bus.mem_we_o, bus.mem_addr_o} !== {1'b0, 32'h20}) begin n_fail++; $display("FAIL both_fetch_bus got we=%b addr=%h want 0/00000020", bus.mem_we_o, bus.mem_addr_o); end
    @(negedge clk_i); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h13; #1;
    n_chk++; if ({bus.dm_rvalid_o, bus.if_rvalid_o} !== 2'b01) begin n_fail++; $display("FAIL both_fetch_rsp dm/if got %b want 01", {bus.dm_rvalid_o, bus.if_rvalid_o}); end
    @(negedge clk_i); bus.mem_rvalid_i = 0; #1;
    n_chk++; if ({bus.dm_rvalid_o, bus.if_rvalid_o, bus.busy_o} !== 3'b000) begin n_fail++; $display("FAIL both_done got %b want 000", {bus.dm_rvalid_o, bus.if_rvalid_o, bus.busy_o}); end
  endtask

  task automatic test_starvation();
    logic exp_if;
    logic [31:0] exp_addr;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      exp_if   = (k == 4) || (k == 9);
      exp_addr = exp_if ? (32'h100 + 32'(k * 4)) : 32'h200;
      @(negedge clk_i);
      bus.if_req_i = 1; bus.if_addr_i = 32'h100 + 32'(k * 4);
      bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h200;
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; #1;
      n_chk++; if ({bus.if_gnt_o, bus.dm_gnt_o} !== {exp_if, ~exp_if}) begin n_fail++; $display("FAIL starve_gnt[%0d] if/dm got %b want %b", k, {bus.if_gnt_o, bus.dm_gnt_o}, {exp_if, ~exp_if}); end
      @(negedge clk_i); bus.mem_gnt_i = 1; #1;
      n_chk++; if (bus.mem_addr_o !== exp_addr) begin n_fail++; $display("FAIL starve_addr[%0d] got %h want %h", k, bus.mem_addr_o, exp_addr); end
      @(negedge clk_i); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'(k); #1;
      n_chk++; if ({bus.if_rvalid_o, bus.dm_rvalid_o} !== {exp_if, ~exp_if}) begin n_fail++; $display("FAIL starve_rvalid[%0d] if/dm got %b want %b", k, {bus.if_rvalid_o, bus.dm_rvalid_o}, {exp_if, ~exp_if}); end
    end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_mem_stall();
    do_reset();
    @(negedge clk_i);
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_be_i = 4'h3; bus.dm_addr_i = 32'h80; bus.dm_wdata_i = 32'h12345678; #1;
    n_chk++; if (bus.dm_gnt_o !== 1'b1) begin n_fail++; $display("FAIL stall_gnt got %b want 1", bus.dm_gnt_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); bus.if_req_i = 1; bus.if_addr_i = 32'h44; bus.mem_gnt_i = 0; bus.mem_rvalid_i = (i == 2); #1;
      n_chk++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.busy_o} !== 7'b1_1_0011_1) begin n_fail++; $display("FAIL stall_ctl[%0d] got %b want 1100111", i, {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.busy_o}); end
      n_chk++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== {32'h80, 32'h12345678}) begin n_fail++; $display("FAIL stall_bus[%0d] got %h/%h want 00000080/12345678", i, bus.mem_addr_o, bus.mem_wdata_o); end
      n_chk++; if ({bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o} !== 4'b0000) begin n_fail++; $display("FAIL stall_pulses[%0d] got %b want 0000", i, {bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o}); end
      n_chk++; if (bus.err_o !== (i == 2)) begin n_fail++; $display("FAIL stall_err[%0d] got %b want %b", i, bus.err_o, (i == 2)); end
    end
    @(negedge clk_i); bus.dm_req_i = 0; bus.mem_rvalid_i = 0; bus.mem_gnt_i = 1; #1;
    n_chk++; if (bus.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b want 1", bus.mem_req_o); end
    @(negedge clk_i); bus.if_req_i = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; #1;
    n_chk++; if ({bus.dm_rvalid_o, bus.if_rvalid_o} !== 2'b10) begin n_fail++; $display("FAIL stall_ack dm/if got %b want 10", {bus.dm_rvalid_o, bus.if_rvalid_o}); end
    @(negedge clk_i); idle_inputs();
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    @(negedge clk_i); bus.if_req_i = 1; bus.if_addr_i = 32'h60;
    @(negedge clk_i); bus.if_req_i = 0; bus.mem_gnt_i = 1;
    @(negedge clk_i); bus.mem_gnt_i = 0; #1;
    n_chk++; if ({bus.busy_o, bus.mem_req_o} !== 2'b10) begin n_fail++; $display("FAIL rst_in_rsp busy/req got %b want 10", {bus.busy_o, bus.mem_req_o}); end
    rst_ni = 0; bus.if_req_i = 1; bus.dm_req_i = 1; bus.mem_rvalid_i = 1; #1;
    n_chk++; if ({bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.err_o} !== 8'h00) begin n_fail++; $display("FAIL rst_ctl_outputs got %b want 00000000", {bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.mem_req_o, bus.mem_we_o, bus.busy_o, bus.err_o}); end
    n_chk++; if ({bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.dm_rdata_o} !== '0) begin n_fail++; $display("FAIL rst_bus_outputs got addr=%h be=%h want 0", bus.mem_addr_o, bus.mem_be_o); end
    @(negedge clk_i);
    rst_ni = 1; bus.if_req_i = 0; bus.dm_req_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hCAFE; #1;
    n_chk++; if ({bus.err_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.busy_o} !== 4'b1000) begin n_fail++; $display("FAIL rst_stray err/ifr/dmr/busy got %b want 1000", {bus.err_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.busy_o}); end
    @(negedge clk_i); bus.mem_rvalid_i = 0; #1;
    n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rst_stray_end got %b want 0", bus.err_o); end
  endtask

  task automatic test_stray_idle();
    do_reset();
    @(negedge clk_i); bus.mem_rvalid_i = 1; #1;
    n_chk++; if ({bus.err_o, bus.busy_o, bus.if_rvalid_o, bus.dm_rvalid_o} !== 4'b1000) begin n_fail++; $display("FAIL stray_pulse got %b want 1000", {bus.err_o, bus.busy_o, bus.if_rvalid_o, bus.dm_rvalid_o}); end
    @(negedge clk_i); bus.mem_rvalid_i = 0; #1;
    n_chk++; if ({bus.err_o, bus.busy_o} !== 2'b00) begin n_fail++; $display("FAIL stray_after got %b want 00", {bus.err_o, bus.busy_o}); end
    @(negedge clk_i); bus.dm_req_i = 1; bus.dm_addr_i = 32'h8; #1;
    n_chk++; if (bus.dm_gnt_o !== 1'b1) begin n_fail++; $display("FAIL stray_still_idle got %b want 1", bus.dm_gnt_o); end
    @(negedge clk_i); idle_inputs(); bus.mem_gnt_i = 1;
    @(negedge clk_i); bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1;
    @(negedge clk_i); bus.mem_rvalid_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    n_chk++; if ({bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.mem_req_o, bus.busy_o, bus.err_o} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs got %b want 0000000", {bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.mem_req_o, bus.busy_o, bus.err_o}); end
    n_chk++; if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== '0) begin n_fail++; $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", bus.mem_addr_o, bus.mem_wdata_o); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_both_requests();
    test_starvation();
    test_mem_stall();
    test_reset_mid_txn();
    test_stray_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
